// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Multi-cycle ripple-borrow subtractor. It computes diff = a - b one digit
//   (DIGIT_WIDTH bits) per clock and carries a registered borrow between
//   digits. Valid/ready handshakes on both sides let it sit between pipelined
//   producers and consumers. It trades latency for a narrow datapath.
//
//   Result format matches the combinational ripple-carry adder:
//     diff       = {final borrow, a - b mod 2^DATA_WIDTH}
//                  (this is a - b as a (DATA_WIDTH+1)-bit two's-complement value)
//     borrow_int = borrow into each bit position (bit 0 is always 0)
//
// Parameters
//   DATA_WIDTH   operand width in bits (>= 1)
//   DIGIT_WIDTH  bits processed per clock; must divide DATA_WIDTH
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    a/b are valid
//   in_ready    operands accepted (high only in IDLE)
//   a, b        unsigned minuend / subtrahend
//   out_valid   diff/borrow_int hold a completed result (DONE)
//   out_ready   consumer takes the result
//   diff        {borrow_out, a-b}
//   borrow_int  per-bit borrow-in vector
//   busy        high in RUN and DONE
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int DATA_WIDTH  = 8,
    parameter int DIGIT_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   diff,
    output logic [DATA_WIDTH-1:0] borrow_int,
    output logic                  busy
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int N  = DATA_WIDTH / DIGIT_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    // Wide enough to hold any bit index 0..DATA_WIDTH-1.
    localparam int IW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (DATA_WIDTH < 1 || DIGIT_WIDTH < 1 || (DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_cfg
            $error("serial_subtractor: DIGIT_WIDTH must be >= 1 and divide DATA_WIDTH (>= 1)");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [CW-1:0]         r_cnt;
    logic                  r_borrow;
    logic [DATA_WIDTH:0]   r_diff;
    logic [DATA_WIDTH-1:0] r_bint;

    // -------------------------------------------------------------------------
    // Digit datapath: one DIGIT_WIDTH-wide ripple-borrow slice
    // -------------------------------------------------------------------------
    logic [IW-1:0]          w_lo;   // lowest bit index of the current digit
    logic [DIGIT_WIDTH-1:0] w_a_dig;
    logic [DIGIT_WIDTH-1:0] w_b_dig;
    logic [DIGIT_WIDTH-1:0] w_d;
    logic [DIGIT_WIDTH:0]   w_br;   // w_br[j] = borrow into bit j of the digit
    logic                   w_accept;
    logic                   w_last;

    always_comb begin
        w_lo    = IW'(r_cnt) * IW'(DIGIT_WIDTH);
        w_a_dig = r_a[w_lo +: DIGIT_WIDTH];
        w_b_dig = r_b[w_lo +: DIGIT_WIDTH];
        w_d     = '0;
        w_br    = '0;
        w_br[0] = r_borrow;
        for (int j = 0; j < DIGIT_WIDTH; j++) begin
            w_d[j]    = w_a_dig[j] ^ w_b_dig[j] ^ w_br[j];
            // Borrow out when a<b at this bit, or when equal and a borrow came in.
            w_br[j+1] = (~w_a_dig[j] & w_b_dig[j]) |
                        (~(w_a_dig[j] ^ w_b_dig[j]) & w_br[j]);
        end
    end

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == LAST);

    // -------------------------------------------------------------------------
    // Control and state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_borrow <= w_br[DIGIT_WIDTH];
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Result registers: written only in RUN, so they hold through DONE and
    // keep their last value in IDLE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff <= '0;
            r_bint <= '0;
        end else if (r_state == S_RUN) begin
            r_diff[w_lo +: DIGIT_WIDTH] <= w_d;
            for (int j = 0; j < DIGIT_WIDTH; j++) begin
                r_bint[w_lo + IW'(j)] <= w_br[j];
            end
            if (w_last) begin
                r_diff[DATA_WIDTH] <= w_br[DIGIT_WIDTH];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign diff       = r_diff;
    assign borrow_int = r_bint;

    // A presented result must equal the difference of the captured operands.
    a_diff_ok: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (diff == ({1'b0, r_a} - {1'b0, r_b})));

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Unit 0: 8-bit, 1-bit digits (N=8). Unit 1: 8-bit, 2-bit digits (N=4).
    logic       iv  [2];
    logic       ir  [2];
    logic [7:0] ia  [2];
    logic [7:0] ib  [2];
    logic       ov  [2];
    logic       orr [2];
    logic [8:0] od  [2];
    logic [7:0] obi [2];
    logic       bsy [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.DATA_WIDTH(8), .DIGIT_WIDTH(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(ia[0]), .b(ib[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .diff(od[0]), .borrow_int(obi[0]), .busy(bsy[0]));

    serial_subtractor #(.DATA_WIDTH(8), .DIGIT_WIDTH(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(ia[1]), .b(ib[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .diff(od[1]), .borrow_int(obi[1]), .busy(bsy[1]));

    // ---------------- reference model ----------------
    function automatic int ndig(input int u);
        return (u == 0) ? 8 : 4;
    endfunction

    function automatic logic [8:0] ref_diff(input logic [7:0] x, input logic [7:0] y);
        int d;
        d = int'(x) - int'(y);
        return 9'(d);
    endfunction

    // A borrow enters bit i exactly when the low i bits of a are below those of b.
    function automatic logic [7:0] ref_bint(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        int m;
        r = '0;
        for (int i = 1; i < 8; i++) begin
            m = (1 << i) - 1;
            r[i] = ((int'(x) & m) < (int'(y) & m));
        end
        return r;
    endfunction

    // ---------------- one full operation ----------------
    task automatic run_op(input int u, input logic [7:0] va, input logic [7:0] vb);
        int cyc;
        bit busy_ok;
        @(negedge clk);
        checks++;
        if (ir[u] !== 1'b1) begin
            errors++; $display("FAIL op_ready u%0d: in_ready=%b want 1", u, ir[u]);
        end
        iv[u] = 1'b1; ia[u] = va; ib[u] = vb;
        @(negedge clk);
        iv[u] = 1'b0; ia[u] = 8'($urandom); ib[u] = 8'($urandom);
        cyc = 0; busy_ok = 1;
        while (ov[u] !== 1'b1 && cyc < 40) begin
            if (bsy[u] !== 1'b1) busy_ok = 0;
            @(negedge clk);
            cyc++;
        end
        if (bsy[u] !== 1'b1) busy_ok = 0;
        checks++;
        if (cyc != ndig(u)) begin
            errors++; $display("FAIL op_latency u%0d a=%h b=%h: %0d edges want %0d", u, va, vb, cyc, ndig(u));
        end
        checks++;
        if (!busy_ok) begin
            errors++; $display("FAIL op_busy u%0d a=%h b=%h: busy dropped, want 1", u, va, vb);
        end
        checks++;
        if (od[u] !== ref_diff(va, vb)) begin
            errors++; $display("FAIL op_diff u%0d a=%h b=%h: got %h want %h", u, va, vb, od[u], ref_diff(va, vb));
        end
        checks++;
        if (obi[u] !== ref_bint(va, vb)) begin
            errors++; $display("FAIL op_bint u%0d a=%h b=%h: got %h want %h", u, va, vb, obi[u], ref_bint(va, vb));
        end
        orr[u] = 1'b1;
        @(negedge clk);
        orr[u] = 1'b0;
        checks++;
        if (ir[u] !== 1'b1 || ov[u] !== 1'b0) begin
            errors++; $display("FAIL op_release u%0d: in_ready=%b out_valid=%b want 1/0", u, ir[u], ov[u]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            iv[u] = 0; ia[u] = 0; ib[u] = 0; orr[u] = 0;
        end
        rst = 1'b1;
        #12;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (ir[u] !== 1'b1 || ov[u] !== 1'b0 || bsy[u] !== 1'b0 || od[u] !== 9'h0 || obi[u] !== 8'h0) begin
                errors++;
                $display("FAIL reset u%0d: rdy=%b ov=%b busy=%b diff=%h bint=%h want 1/0/0/000/00",
                         u, ir[u], ov[u], bsy[u], od[u], obi[u]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        va = '{8'h05, 8'h00, 8'h80, 8'hFF};
        vb = '{8'h03, 8'h01, 8'h7F, 8'hFF};
        for (int u = 0; u < 2; u++)
            for (int k = 0; k < 4; k++)
                run_op(u, va[k], vb[k]);
    endtask

    task automatic test_backpressure();
        logic [8:0] hold_d;
        logic [7:0] hold_b;
        int cyc;
        @(negedge clk);
        iv[0] = 1'b1; ia[0] = 8'h9A; ib[0] = 8'h3C;
        @(negedge clk);
        iv[0] = 1'b0;
        cyc = 0;
        while (ov[0] !== 1'b1 && cyc < 40) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (ov[0] !== 1'b1) begin
            errors++; $display("FAIL bp_done: out_valid=%b want 1", ov[0]);
        end
        hold_d = od[0]; hold_b = obi[0];
        checks++;
        if (hold_d !== ref_diff(8'h9A, 8'h3C)) begin
            errors++; $display("FAIL bp_diff: got %h want %h", hold_d, ref_diff(8'h9A, 8'h3C));
        end
        for (int i = 0; i < 5; i++) begin
            orr[0] = 1'b0; iv[0] = 1'b1; ia[0] = 8'h11; ib[0] = 8'h22;
            @(negedge clk);
            checks++;
            if (od[0] !== hold_d || obi[0] !== hold_b || ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: diff=%h bint=%h rdy=%b ov=%b want %h/%h/0/1",
                         i, od[0], obi[0], ir[0], ov[0], hold_d, hold_b);
            end
        end
        orr[0] = 1'b1; iv[0] = 1'b0;
        @(negedge clk);
        orr[0] = 1'b0;
        checks++;
        if (ir[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            errors++; $display("FAIL bp_release: in_ready=%b busy=%b want 1/0", ir[0], bsy[0]);
        end
        run_op(0, 8'h11, 8'h01);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        iv[0] = 1'b1; ia[0] = 8'h33; ib[0] = 8'h44;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || bsy[0] !== 1'b0 || ir[0] !== 1'b1 || od[0] !== 9'h0 || obi[0] !== 8'h0) begin
            errors++;
            $display("FAIL rst_mid_run: ov=%b busy=%b rdy=%b diff=%h bint=%h want 0/0/1/000/00",
                     ov[0], bsy[0], ir[0], od[0], obi[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 8'h10, 8'h20);
    endtask

    task automatic test_random_soak(input int u, input int nops);
        logic [7:0] qa [$];
        logic [7:0] qb [$];
        int results, cyc, acc_cyc;
        bit seen, v;
        results = 0; cyc = 0; acc_cyc = 0; seen = 0;
        while (results < nops && cyc < nops * 60) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (bsy[u] !== ~ir[u]) begin
                errors++; $display("FAIL soak_busy u%0d: busy=%b in_ready=%b", u, bsy[u], ir[u]);
            end
            if (ov[u] === 1'b1 && !seen) begin
                seen = 1;
                checks++;
                if (qa.size() == 0) begin
                    errors++; $display("FAIL soak_spurious u%0d: out_valid=1 with nothing accepted", u);
                end else begin
                    if ((cyc - acc_cyc - 1) != ndig(u)) begin
                        errors++; $display("FAIL soak_latency u%0d: %0d want %0d", u, cyc - acc_cyc - 1, ndig(u));
                    end
                    checks++;
                    if (od[u] !== ref_diff(qa[0], qb[0]) || obi[u] !== ref_bint(qa[0], qb[0])) begin
                        errors++;
                        $display("FAIL soak_result u%0d a=%h b=%h: diff=%h bint=%h want %h/%h", u, qa[0], qb[0],
                                 od[u], obi[u], ref_diff(qa[0], qb[0]), ref_bint(qa[0], qb[0]));
                    end
                end
            end
            v = 1'($urandom_range(0, 1));
            iv[u] = v; ia[u] = 8'($urandom); ib[u] = 8'($urandom);
            orr[u] = 1'($urandom_range(0, 1));
            if (ir[u] === 1'b1 && v) begin
                qa.push_back(ia[u]); qb.push_back(ib[u]); acc_cyc = cyc;
            end
            if (ov[u] === 1'b1 && orr[u]) begin
                if (qa.size() > 0) begin
                    void'(qa.pop_front()); void'(qb.pop_front());
                end
                results++; seen = 0;
            end
        end
        checks++;
        if (results < nops) begin
            errors++; $display("FAIL soak_timeout u%0d: %0d results want %0d", u, results, nops);
        end
        // Drain: finish any in-flight operation and return to IDLE.
        iv[u] = 1'b0; orr[u] = 1'b1;
        repeat (12) @(negedge clk);
        orr[u] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_random_soak(0, 1200);
        test_random_soak(1, 1200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
